evg_event_arbiter: RTL
======================

# evg_event_arbiter

Merges the event-code sources of the event generator into the single event-code slot of the transmitter word, one code per `evgTxClk` cycle. The sources are the sequencer, the heartbeat request, the hardware triggers and the software trigger. It sits between the source blocks and the 8b10b word builder, in the transmit clock domain. It owns priority, backpressure (TREADY), heartbeat insertion and collision statistics.

## Interface
Parameters:
- `HEARTBEAT_EVENT_CODE`, 8'h7A: code emitted for a heartbeat request.
- `STARVE_LIMIT`, 64: cycles the software source may wait before promotion (guard only).
- `STAT_WIDTH`, 16: width of each saturating statistics counter.

Ports:
- `evgTxClk`  in  1: transmit clock. The only clock.
- `evgTxRst`  in  1: reset, synchronous, active-high.
- `evgSequenceEventTDATA`  in  8: sequencer code.
- `evgSequenceEventTVALID`  in  1: sequencer valid. There is no ready; the sequencer is always accepted.
- `evgHeartbeatRequest`  in  1: single-cycle request pulse.
- `evgHardwareEventTDATA`  in  8: hardware trigger code.
- `evgHardwareEventTVALID`  in  1: hardware trigger valid.
- `evgHardwareEventTREADY`  out  1: hardware trigger accept.
- `evgSoftwareEventTDATA`  in  8: software trigger code.
- `evgSoftwareEventTVALID`  in  1: software trigger valid.
- `evgSoftwareEventTREADY`  out  1: software trigger accept.
- `evgStatClear`  in  1: single-cycle pulse; zeroes all counters.
- `evgEventCode`  out  8: code for the transmitter slot. 8'h00 means null/idle.
- `evgEventValid`  out  1: `evgEventCode` is a real event.
- `evgHeartbeatOverrun`  out  STAT_WIDTH: requests received while a heartbeat was already pending.
- `evgNullDiscards`  out  STAT_WIDTH: code-0 transfers accepted and dropped.
- `evgSoftwareStalls`  out  STAT_WIDTH: cycles the software source was valid but not granted.

## Operation
- **Pending heartbeat flag `hbPend`.**
  - Set by `evgHeartbeatRequest`.
  - Cleared when the heartbeat is granted.
  - A request arriving while `hbPend` is set, and not being granted that cycle, increments `evgHeartbeatOverrun`. The flag stays set; heartbeats do not queue.
- **Grant order, evaluated combinationally each cycle:**
  1. Sequencer, if TVALID.
  2. Heartbeat, if `hbPend`.
  3. Hardware, if TVALID.
  4. Software, if TVALID.
- **Promotion (guard only):** software is promoted above heartbeat and hardware, but never above the sequencer.
- **Ready signals:**
  - `evgHardwareEventTREADY` is asserted exactly when hardware is granted.
  - `evgSoftwareEventTREADY` is asserted exactly when software is granted.
  - Both are combinational from the TVALIDs and state, with no dependence on the outputs.
  - At most one grant per cycle.
- **Code 0:** a hardware or software transfer with TDATA = 0 is accepted (READY high) and counts into `evgNullDiscards`. The slot is output as null (valid 0, code 0). A sequencer code of 0 is output as null and is not counted.
- **Stall count:** `evgSoftwareStalls` increments on each cycle with software TVALID high and READY low.
- **Counters:** all counters saturate at all-ones. `evgStatClear` takes precedence over an increment in the same cycle.
- **Waiting state machine (guard only), states IDLE / WAIT / PROMOTED:**
  - IDLE → WAIT when software is valid and not granted. The wait counter loads 1.
  - In WAIT, the counter increments per ungranted cycle.
  - WAIT → PROMOTED when the counter reaches `STARVE_LIMIT`.
  - Any state → IDLE on a software grant, or when software TVALID drops.

## Timing
- Output latency is 1 cycle: a grant in cycle N produces `evgEventCode`/`evgEventValid` in cycle N+1. Both outputs are registered.
- **Heartbeat latency:** a request in cycle N is granted no earlier than cycle N+1, because `hbPend` is registered. With no competing sources, the code appears in N+2.
- **Simultaneous events:**
  - A request arriving in the same cycle that a pending heartbeat is granted sets `hbPend` again. No overrun is counted.
  - Sequencer valid on every cycle starves all other sources indefinitely. This is by design and is not counted except through software stalls.
- **Reset (synchronous, any cycle, including mid-grant):**
  - `evgEventCode` = 0, `evgEventValid` = 0, both READYs = 0.
  - `hbPend` = 0, state IDLE, wait counter 0, all statistics 0.
  - READYs are held low while `evgTxRst` is high.

## Configuration
- `EVG_ARB_STARVATION_GUARD_EN`
  - **Defined:** the waiting state machine, the wait counter and software promotion are compiled in.
  - **Undefined:** strict fixed priority, with no FSM or counter logic. `STARVE_LIMIT` is ignored. `evgSoftwareStalls` is still present.

## Structure
- **Shared package `evg_pkg`:**
  - `EVENTCODE_WIDTH` = 8.
  - Null code 8'h00.
  - Default heartbeat code 8'h7A.
  - Source enumeration typedef {SRC_NONE, SRC_SEQ, SRC_HB, SRC_HW, SRC_SW}.
  - Guard-state typedef {IDLE, WAIT, PROMOTED}.
- **Sub-module `evg_sat_counter`:** one natural sub-module with parameter width, increment and clear inputs. It is instantiated three times.

## Test plan
- **Reset and idle:** reset asserted for 3 cycles with all inputs idle → outputs code 0, valid 0, READYs 0. After release, all counters read 0.
- **Sequencer beats hardware:** sequencer 8'h10 and hardware 8'h22 both valid in cycle N → 8'h10 output in N+1, hardware READY low in N. Hardware is granted in N+1 and 8'h22 is output in N+2.
- **Heartbeat overrun:** heartbeat pulse plus continuous sequencer valid for 5 cycles, with a second pulse in cycle 2 → overrun = 1. A single 8'h7A appears once the sequencer drops.
- **Null discard:** software TDATA 8'h00 valid with no other sources → READY high for 1 cycle, null output, `evgNullDiscards` = 1.
- **Starvation (macro defined, `STARVE_LIMIT` = 4):** hardware and software valid continuously → software granted after 4 stalls, before further hardware grants. With the macro undefined, software is never granted while hardware is valid.
- **Saturation and clear:** `STAT_WIDTH` = 4 with 20 software stall cycles → `evgSoftwareStalls` = 15. An `evgStatClear` pulse in the same cycle as a stall → 0.

Source files
------------

// File: rtl/evg_pkg.sv
// rtl/evg_pkg.sv - shared event generator types and constants
package evg_pkg;

    localparam int EVENTCODE_WIDTH = 8;
    localparam logic [EVENTCODE_WIDTH-1:0] NULL_CODE = 8'h00;
    localparam logic [EVENTCODE_WIDTH-1:0] DEFAULT_HEARTBEAT_CODE = 8'h7A;

    // Which source owns the transmitter event slot this cycle
    typedef enum logic [2:0] {
        SRC_NONE,
        SRC_SEQ,
        SRC_HB,
        SRC_HW,
        SRC_SW
    } evgSrc_t;

    // Software starvation guard states
    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        PROMOTED
    } evgGuardState_t;

endpackage

// File: rtl/evg_sat_counter.sv
// rtl/evg_sat_counter.sv - saturating statistics counter with synchronous clear
module evg_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Clear wins over increment; the count sticks at all-ones
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/evg_event_arbiter.sv
// rtl/evg_event_arbiter.sv - event code source arbiter; EVG_ARB_STARVATION_GUARD_EN enables software promotion
module evg_event_arbiter
    import evg_pkg::*;
#(
    parameter logic [EVENTCODE_WIDTH-1:0] HEARTBEAT_EVENT_CODE = DEFAULT_HEARTBEAT_CODE,
    parameter int STARVE_LIMIT = 64,
    parameter int STAT_WIDTH = 16
) (
    input  logic                       evgTxClk,
    input  logic                       evgTxRst,
    input  logic [EVENTCODE_WIDTH-1:0] evgSequenceEventTDATA,
    input  logic                       evgSequenceEventTVALID,
    input  logic                       evgHeartbeatRequest,
    input  logic [EVENTCODE_WIDTH-1:0] evgHardwareEventTDATA,
    input  logic                       evgHardwareEventTVALID,
    output logic                       evgHardwareEventTREADY,
    input  logic [EVENTCODE_WIDTH-1:0] evgSoftwareEventTDATA,
    input  logic                       evgSoftwareEventTVALID,
    output logic                       evgSoftwareEventTREADY,
    input  logic                       evgStatClear,
    output logic [EVENTCODE_WIDTH-1:0] evgEventCode,
    output logic                       evgEventValid,
    output logic [STAT_WIDTH-1:0]      evgHeartbeatOverrun,
    output logic [STAT_WIDTH-1:0]      evgNullDiscards,
    output logic [STAT_WIDTH-1:0]      evgSoftwareStalls
);

    evgSrc_t grant;
    logic    hbPend;
    logic    swPromoted;
    logic    overrunInc;
    logic    nullInc;
    logic    stallInc;

`ifdef EVG_ARB_STARVATION_GUARD_EN
    localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(STARVE_LIMIT);

    evgGuardState_t    guardState;
    logic [WAIT_W-1:0] waitCnt;

    assign swPromoted = (guardState == PROMOTED);

    // Count consecutive ungranted software cycles and promote at the limit
    always_ff @(posedge evgTxClk) begin
        if (evgTxRst) begin
            guardState <= IDLE;
            waitCnt    <= '0;
        end else if (!evgSoftwareEventTVALID || (grant == SRC_SW)) begin
            guardState <= IDLE;
            waitCnt    <= '0;
        end else begin
            case (guardState)
                IDLE: begin
                    waitCnt    <= WAIT_W'(1);
                    guardState <= (WAIT_LIMIT <= WAIT_W'(1)) ? PROMOTED : WAIT;
                end
                WAIT: begin
                    waitCnt <= waitCnt + 1'b1;
                    if ((waitCnt + 1'b1) == WAIT_LIMIT) begin
                        guardState <= PROMOTED;
                    end
                end
                default: begin
                end
            endcase
        end
    end
`else
    localparam int unusedStarveLimit = STARVE_LIMIT;

    assign swPromoted = 1'b0;
`endif

    // Fixed priority; a promoted software source only yields to the sequencer
    always_comb begin
        grant = SRC_NONE;
        if (evgTxRst) begin
            grant = SRC_NONE;
        end else if (evgSequenceEventTVALID) begin
            grant = SRC_SEQ;
        end else if (swPromoted && evgSoftwareEventTVALID) begin
            grant = SRC_SW;
        end else if (hbPend) begin
            grant = SRC_HB;
        end else if (evgHardwareEventTVALID) begin
            grant = SRC_HW;
        end else if (evgSoftwareEventTVALID) begin
            grant = SRC_SW;
        end
    end

    assign evgHardwareEventTREADY = (grant == SRC_HW);
    assign evgSoftwareEventTREADY = (grant == SRC_SW);

    // A new request re-arms the flag even in the cycle the old one is granted
    always_ff @(posedge evgTxClk) begin
        if (evgTxRst) begin
            hbPend <= 1'b0;
        end else if (evgHeartbeatRequest) begin
            hbPend <= 1'b1;
        end else if (grant == SRC_HB) begin
            hbPend <= 1'b0;
        end
    end

    // Register the granted code; code 0 always leaves the slot null
    always_ff @(posedge evgTxClk) begin
        if (evgTxRst) begin
            evgEventCode  <= NULL_CODE;
            evgEventValid <= 1'b0;
        end else begin
            case (grant)
                SRC_SEQ: begin
                    evgEventCode  <= evgSequenceEventTDATA;
                    evgEventValid <= (evgSequenceEventTDATA != NULL_CODE);
                end
                SRC_HB: begin
                    evgEventCode  <= HEARTBEAT_EVENT_CODE;
                    evgEventValid <= (HEARTBEAT_EVENT_CODE != NULL_CODE);
                end
                SRC_HW: begin
                    evgEventCode  <= evgHardwareEventTDATA;
                    evgEventValid <= (evgHardwareEventTDATA != NULL_CODE);
                end
                SRC_SW: begin
                    evgEventCode  <= evgSoftwareEventTDATA;
                    evgEventValid <= (evgSoftwareEventTDATA != NULL_CODE);
                end
                default: begin
                    evgEventCode  <= NULL_CODE;
                    evgEventValid <= 1'b0;
                end
            endcase
        end
    end

    assign overrunInc = evgHeartbeatRequest && hbPend && (grant != SRC_HB);
    assign nullInc    = (evgHardwareEventTREADY && (evgHardwareEventTDATA == NULL_CODE)) ||
                        (evgSoftwareEventTREADY && (evgSoftwareEventTDATA == NULL_CODE));
    assign stallInc   = evgSoftwareEventTVALID && !evgSoftwareEventTREADY;

    evg_sat_counter #(.WIDTH(STAT_WIDTH)) overrunCounter (
        .clk   (evgTxClk),
        .rst   (evgTxRst),
        .clear (evgStatClear),
        .inc   (overrunInc),
        .count (evgHeartbeatOverrun)
    );

    evg_sat_counter #(.WIDTH(STAT_WIDTH)) nullCounter (
        .clk   (evgTxClk),
        .rst   (evgTxRst),
        .clear (evgStatClear),
        .inc   (nullInc),
        .count (evgNullDiscards)
    );

    evg_sat_counter #(.WIDTH(STAT_WIDTH)) stallCounter (
        .clk   (evgTxClk),
        .rst   (evgTxRst),
        .clear (evgStatClear),
        .inc   (stallInc),
        .count (evgSoftwareStalls)
    );

endmodule
